// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM definitions: command encodings, init sequencer states and helpers.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  // A10 high during PRECHARGE selects all banks.
  localparam int unsigned A10_BIT = 10;

  typedef enum logic [3:0] {
    StWaitPwr,
    StWaitReady,
    StPrecharge,
    StWaitRp,
    StRefresh,
    StWaitRfc,
    StLoadMode,
    StWaitMrd,
    StDone
  } init_state_e;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_delay_timer.sv
// Loadable down-counter with zero and last-tick flags; saturates at zero.
module sdram_delay_timer #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  // Set on the final cycle of a wait: the decrement this cycle reaches zero.
  assign last_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/sdram_init_sequencer.sv
// JEDEC SDR SDRAM power-up sequencer: drives the command bus until init completes,
// then hands the bus to the main controller; supports re-init without the power-up wait.
module sdram_init_sequencer
  import sdram_pkg::*;
#(
  parameter int                    POWER_UP_CYCLES  = 20000,
  parameter int                    T_RP_CYCLES      = 2,
  parameter int                    T_RFC_CYCLES     = 7,
  parameter int                    T_MRD_CYCLES     = 2,
  parameter int                    NUM_INIT_REFRESH = 2,
  parameter int                    ADDR_WIDTH       = 13,
  parameter int                    BA_WIDTH         = 2,
  parameter logic [ADDR_WIDTH-1:0] MODE_REG_VALUE   = 'h033
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  sdram_ready_i,
  input  logic                  reinit_req_i,
  output logic [3:0]            cmd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [BA_WIDTH-1:0]   ba_o,
  output logic                  cke_o,
  output logic                  init_busy_o,
  output logic                  init_done_o
);

  if (POWER_UP_CYCLES < 1) begin : g_bad_pwr
    $error("POWER_UP_CYCLES must be >= 1");
  end
  if (T_RP_CYCLES < 1) begin : g_bad_rp
    $error("T_RP_CYCLES must be >= 1");
  end
  if (T_RFC_CYCLES < 1) begin : g_bad_rfc
    $error("T_RFC_CYCLES must be >= 1");
  end
  if (T_MRD_CYCLES < 1) begin : g_bad_mrd
    $error("T_MRD_CYCLES must be >= 1");
  end
  if ((NUM_INIT_REFRESH < 1) || (NUM_INIT_REFRESH > 15)) begin : g_bad_nref
    $error("NUM_INIT_REFRESH must be in 1..15");
  end
  if (ADDR_WIDTH < 11) begin : g_bad_aw
    $error("ADDR_WIDTH must be >= 11");
  end

  localparam int unsigned MaxTiming = max_of(max_of(POWER_UP_CYCLES, T_RP_CYCLES),
                                             max_of(T_RFC_CYCLES, T_MRD_CYCLES));
  localparam int unsigned TimerW    = $clog2(MaxTiming) + 1;

  localparam logic [TimerW-1:0] PwrLoad = TimerW'(POWER_UP_CYCLES);
  localparam logic [TimerW-1:0] RpLoad  = TimerW'(T_RP_CYCLES - 1);
  localparam logic [TimerW-1:0] RfcLoad = TimerW'(T_RFC_CYCLES - 1);
  localparam logic [TimerW-1:0] MrdLoad = TimerW'(T_MRD_CYCLES - 1);
  localparam logic [4:0]        NumRef  = 5'(NUM_INIT_REFRESH);

  init_state_e state_q, state_d;
  logic [3:0]  ref_q, ref_d;

  logic              tmr_load, tmr_dec, tmr_zero, tmr_last, tmr_expired;
  logic [TimerW-1:0] tmr_val;

  logic [3:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BA_WIDTH-1:0]   ba_q, ba_d;
  logic                  cke_q, cke_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  sdram_delay_timer #(
    .WIDTH     (TimerW),
    .RESET_VAL (PwrLoad)
  ) u_timer (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero),
    .last_o     (tmr_last)
  );

  // Zero counts as expired too so a wait can never stall on an empty timer.
  assign tmr_expired = tmr_last | tmr_zero;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      StWaitPwr: begin
        tmr_dec = 1'b1;
        if (tmr_expired) state_d = StWaitReady;
      end
      StWaitReady: begin
        if (sdram_ready_i) state_d = StPrecharge;
      end
      StPrecharge: begin
        if (T_RP_CYCLES > 1) begin
          state_d  = StWaitRp;
          tmr_load = 1'b1;
          tmr_val  = RpLoad;
        end else begin
          state_d = StRefresh;
        end
      end
      StWaitRp: begin
        tmr_dec = 1'b1;
        if (tmr_expired) state_d = StRefresh;
      end
      StRefresh: begin
        ref_d = ref_q + 4'd1;
        if (T_RFC_CYCLES > 1) begin
          state_d  = StWaitRfc;
          tmr_load = 1'b1;
          tmr_val  = RfcLoad;
        end else begin
          state_d = (({1'b0, ref_q} + 5'd1) < NumRef) ? StRefresh : StLoadMode;
        end
      end
      StWaitRfc: begin
        tmr_dec = 1'b1;
        if (tmr_expired) state_d = ({1'b0, ref_q} < NumRef) ? StRefresh : StLoadMode;
      end
      StLoadMode: begin
        if (T_MRD_CYCLES > 1) begin
          state_d  = StWaitMrd;
          tmr_load = 1'b1;
          tmr_val  = MrdLoad;
        end else begin
          state_d = StDone;
        end
      end
      StWaitMrd: begin
        tmr_dec = 1'b1;
        if (tmr_expired) state_d = StDone;
      end
      StDone: begin
        if (reinit_req_i) begin
          state_d = StWaitReady;
          ref_d   = '0;
        end
      end
      default: state_d = StWaitPwr;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus tracks state_q.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    cke_d  = (state_d != StWaitPwr);
    busy_d = (state_d != StDone);
    done_d = (state_d == StDone);
    unique case (state_d)
      StWaitPwr:   cmd_d = CMD_INHIBIT;
      StPrecharge: begin
        cmd_d           = CMD_PRECHARGE;
        addr_d[A10_BIT] = 1'b1;
      end
      StRefresh:   cmd_d = CMD_REFRESH;
      StLoadMode: begin
        cmd_d  = CMD_LOAD_MODE;
        addr_d = MODE_REG_VALUE;
      end
      default:     cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= StWaitPwr;
      ref_q   <= '0;
      cmd_q   <= CMD_INHIBIT;
      addr_q  <= '0;
      ba_q    <= '0;
      cke_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      cke_q   <= cke_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_o       = cmd_q;
  assign addr_o      = addr_q;
  assign ba_o        = ba_q;
  assign cke_o       = cke_q;
  assign init_busy_o = busy_q;
  assign init_done_o = done_q;

endmodule
